// File: rtl/ili9341_pkg.sv
// Shared definitions for the ILI9341 frame path: scaler FSM states,
// RGB565 colour constants and small address/width helpers.
package ili9341_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE  = 16'h001F;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned width_for(int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // First ROM word of image 'sel' when images are stored back-to-back.
    function automatic int unsigned img_base(int unsigned sel, int unsigned w, int unsigned h);
        return sel * w * h;
    endfunction

endpackage

// File: rtl/ili9341_frame_scaler_scale_counter.sv
// Generic wrapping counter 0..limit_i. wrap_o flags the enabled cycle in
// which the count returns to zero, so instances chain through wrap_o.
// next_o exposes the value the counter will hold after this edge.
module scale_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] next_o,
    output logic         wrap_o
);

    logic [W-1:0] count_q, count_d;

    assign wrap_o = en_i && (count_q == limit_i);
    assign next_o = count_d;

    // Next count: clear wins, otherwise step or wrap when enabled.
    always_comb begin
        // NOTE: default assignment first, so no path leaves count_d unassigned and no latch is inferred.
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = wrap_o ? '0 : count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end

endmodule

// File: rtl/ili9341_frame_scaler.sv
// Frame source for ili9341_controller: reads one of IMAGES SRC_W x SRC_H
// images from a 1-cycle synchronous ROM and streams it upscaled by SCALE
// in raster order over a valid/ready interface.
// Optional macro ILI_SCALER_MIRROR_EN adds mirror_i for horizontal flip.
module ili9341_frame_scaler
    import ili9341_pkg::*;
#(
    parameter int unsigned SRC_W      = 80,
    parameter int unsigned SRC_H      = 80,
    parameter int unsigned SCALE      = 3,
    parameter int unsigned PIXEL_SIZE = 16,
    parameter int unsigned IMAGES     = 5,
    parameter int unsigned ADDR_W     = width_for(IMAGES * SRC_W * SRC_H),
    parameter int unsigned SEL_W      = width_for(IMAGES)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [SEL_W-1:0]      img_sel_i,
`ifdef ILI_SCALER_MIRROR_EN
    input  logic                  mirror_i,
`endif
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic                  mem_rd_o,
    input  logic [PIXEL_SIZE-1:0] mem_data_i,
    output logic [PIXEL_SIZE-1:0] pix_data_o,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int unsigned XW = width_for(SRC_W);
    localparam int unsigned YW = width_for(SRC_H);
    localparam int unsigned RW = width_for(SCALE);
    localparam logic [XW-1:0] X_LAST = XW'(SRC_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SRC_H - 1);
    localparam logic [RW-1:0] R_LAST = RW'(SCALE - 1);

    state_e                  state_q;
    logic [ADDR_W-1:0]       base_q, base_d, fetch_addr_d;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic                    mem_rd_q, pix_valid_q, busy_q, frame_done_q;
    logic [PIXEL_SIZE-1:0]   pix_data_q;
    logic [SEL_W-1:0]        sel_d;
    logic [XW-1:0]           sx_next, col_d;
    logic [YW-1:0]           sy_next;
    logic [RW-1:0]           rx_next_unused, ry_next_unused;
    logic                    frame_start, hs;
    logic                    rx_wrap, sx_wrap, ry_wrap, sy_wrap;

    assign frame_start = (state_q == IDLE) && start_i;
    assign hs          = (state_q == STREAM) && pix_valid_q && pix_ready_i;

    // Out-of-range selectors fall back to image 0.
    assign sel_d  = (32'(img_sel_i) < IMAGES) ? img_sel_i : '0;
    assign base_d = frame_start ? ADDR_W'(img_base(32'(sel_d), SRC_W, SRC_H)) : base_q;

`ifdef ILI_SCALER_MIRROR_EN
    logic mirror_q, mirror_d;
    assign mirror_d = frame_start ? mirror_i : mirror_q;
    assign col_d    = mirror_d ? X_LAST - sx_next : sx_next;
`else
    assign col_d    = sx_next;
`endif

    // Address of the source pixel the counters hold after this edge, so the
    // registered read strobe and address are already on the bus during FETCH
    // and the ROM data is ready to capture at the end of WAIT.
    assign fetch_addr_d = base_d + ADDR_W'(sy_next) * ADDR_W'(SRC_W) + ADDR_W'(col_d);

    // Counter chain: rep_x -> src_x -> rep_y -> src_y; src_y wrap marks the last pixel.
    scale_counter #(.W(RW)) u_rep_x (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(frame_start), .en_i(hs),
        .limit_i(R_LAST), .next_o(rx_next_unused), .wrap_o(rx_wrap));
    scale_counter #(.W(XW)) u_src_x (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(frame_start), .en_i(rx_wrap),
        .limit_i(X_LAST), .next_o(sx_next), .wrap_o(sx_wrap));
    scale_counter #(.W(RW)) u_rep_y (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(frame_start), .en_i(sx_wrap),
        .limit_i(R_LAST), .next_o(ry_next_unused), .wrap_o(ry_wrap));
    scale_counter #(.W(YW)) u_src_y (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(frame_start), .en_i(ry_wrap),
        .limit_i(Y_LAST), .next_o(sy_next), .wrap_o(sy_wrap));

    // Frame FSM with registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            base_q       <= '0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef ILI_SCALER_MIRROR_EN
            mirror_q     <= 1'b0;
`endif
        end else begin
            mem_rd_q     <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        base_q     <= base_d;
`ifdef ILI_SCALER_MIRROR_EN
                        mirror_q   <= mirror_d;
`endif
                        mem_addr_q <= fetch_addr_d;
                        mem_rd_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= FETCH;
                    end
                end
                FETCH: state_q <= WAIT;
                WAIT: begin
                    pix_data_q  <= mem_data_i;
                    pix_valid_q <= 1'b1;
                    state_q     <= STREAM;
                end
                STREAM: begin
                    if (hs && sy_wrap) begin
                        pix_valid_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= DONE;
                    end else if (hs && rx_wrap) begin
                        pix_valid_q <= 1'b0;
                        mem_addr_q  <= fetch_addr_d;
                        mem_rd_q    <= 1'b1;
                        state_q     <= FETCH;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr_o   = mem_addr_q;
    assign mem_rd_o     = mem_rd_q;
    assign pix_data_o   = pix_data_q;
    assign pix_valid_o  = pix_valid_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_ili9341_frame_scaler.sv
// Self-checking bench for ili9341_frame_scaler, built with a reduced image
// size so full frames stay short. Expected pixels come from a raster-order
// model: output index -> (row, col) -> source (x, y) -> ROM word.
module tb_ili9341_frame_scaler;

    localparam int SRC_W  = 8;
    localparam int SRC_H  = 6;
    localparam int SCALE  = 3;
    localparam int IMAGES = 5;
    localparam int PIXW   = 16;
    localparam int ROM_N  = IMAGES * SRC_W * SRC_H;
    localparam int ADDR_W = $clog2(ROM_N);
    localparam int SEL_W  = 3;
    localparam int NPIX   = SRC_W * SRC_H * SCALE * SCALE;
    localparam int BUDGET = 8 * NPIX + 200;

    logic              clk, rst_n, start, mirror, pix_ready;
    logic [SEL_W-1:0]  img_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [PIXW-1:0]   mem_data, pix_data;
    logic              pix_valid, busy, frame_done;

    int n_cmp, n_bad;
    logic [PIXW-1:0] rom [ROM_N];
    logic [PIXW-1:0] got[$];
    logic [PIXW-1:0] ref_seq[$];
    int first_addr, last_addr, n_done, lat;

    ili9341_frame_scaler #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE(SCALE), .PIXEL_SIZE(PIXW), .IMAGES(IMAGES)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .img_sel_i(img_sel),
`ifdef ILI_SCALER_MIRROR_EN
        .mirror_i(mirror),
`endif
        .mem_addr_o(mem_addr), .mem_rd_o(mem_rd), .mem_data_i(mem_data),
        .pix_data_o(pix_data), .pix_valid_o(pix_valid), .pix_ready_i(pix_ready),
        .busy_o(busy), .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data one cycle after the strobe, noise otherwise.
    always @(posedge clk) mem_data <= mem_rd ? rom[mem_addr] : PIXW'($urandom);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PIXW-1:0] exp_pix(input int sel, input int k, input bit mir);
        int base, row, col, sx, sy;
        base = ((sel < IMAGES) ? sel : 0) * SRC_W * SRC_H;
        row  = k / (SRC_W * SCALE);
        col  = k % (SRC_W * SCALE);
        sx   = col / SCALE;
        sy   = row / SCALE;
        if (mir) sx = SRC_W - 1 - sx;
        return rom[base + sy * SRC_W + sx];
    endfunction

    function automatic logic [PIXW-1:0] pix_at(input int i);
        if (i < got.size()) return got[i];
        return 'x;
    endfunction

    // Starts a frame and collects every accepted pixel until frame_done.
    task automatic run_frame(input int sel, input bit rand_ready, input int poke_at,
                             input int rst_at, input bit mir);
        int cyc, k;
        bit stalled, done_seen;
        logic [PIXW-1:0] held;
        got.delete();
        first_addr = -1; last_addr = -1; n_done = 0; lat = -1;
        cyc = 0; k = 0; stalled = 0; done_seen = 0; held = '0;
        @(negedge clk);
        img_sel = SEL_W'(sel); mirror = mir; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done_seen && cyc < BUDGET) begin
            if (start) start = 1'b0;
            if (mem_rd) begin
                if (first_addr < 0) first_addr = int'(mem_addr);
                last_addr = int'(mem_addr);
            end
            if (pix_valid && lat < 0) lat = cyc;
            if (stalled) begin
                check("stall_valid_held", pix_valid, 1);
                check("stall_data_held", pix_data, held);
            end
            if (frame_done) begin
                n_done++;
                check("busy_low_at_done", busy, 0);
                done_seen = 1;
            end
            if (k == rst_at) begin
                check("busy_before_reset", busy, 1);
                rst_n = 1'b0;
                #1;
                check("rst_pix_valid", pix_valid, 0);
                check("rst_pix_data", pix_data, 0);
                check("rst_busy", busy, 0);
                check("rst_mem_rd", mem_rd, 0);
                check("rst_mem_addr", mem_addr, 0);
                check("rst_frame_done", frame_done, 0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    if (frame_done) n_done++;
                end
                check("no_done_after_reset", n_done, 0);
                check("idle_after_reset", busy, 0);
                pix_ready = 1'b1;
                return;
            end
            pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k == poke_at) begin
                start   = 1'b1;
                img_sel = SEL_W'((sel + 1) % IMAGES);
                mirror  = !mir;
                poke_at = -1;
            end
            if (pix_valid && pix_ready) begin
                got.push_back(pix_data);
                k++;
            end
            stalled = pix_valid && !pix_ready;
            held    = pix_data;
            @(negedge clk);
            cyc++;
        end
        check("frame_done_within_budget", done_seen, 1);
        repeat (3) begin
            @(negedge clk);
            if (frame_done) n_done++;
        end
        pix_ready = 1'b1;
    endtask

    task automatic verify_frame(input int sel, input bit mir);
        check("pixel_count", got.size(), NPIX);
        check("frame_done_pulses", n_done, 1);
        check("first_valid_latency", lat, 2);
        for (int i = 0; i < got.size(); i++)
            check($sformatf("pix[%0d]", i), got[i], exp_pix(sel, i, mir));
    endtask

    initial begin
        int diffs, rsel;
        clk = 0; rst_n = 0; start = 0; img_sel = '0; mirror = 0; pix_ready = 1;
        n_cmp = 0; n_bad = 0;
        for (int i = 0; i < ROM_N; i++) rom[i] = PIXW'(i);

        #1;
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_rd", mem_rd, 0);
        check("reset_pix_data", pix_data, 0);
        check("reset_pix_valid", pix_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Image 0, always ready.
        run_frame(0, 0, -1, -1, 0);
        verify_frame(0, 0);
        check("f1_pix0", pix_at(0), 0);
        check("f1_pix2", pix_at(2), 0);
        check("f1_pix3", pix_at(3), 1);
        check("f1_pix5", pix_at(5), 1);
        check("f1_row1_col0", pix_at(SRC_W * SCALE), 0);
        check("f1_row3_col0", pix_at(3 * SRC_W * SCALE), SRC_W);
        check("f1_first_addr", first_addr, 0);
        check("f1_last_addr", last_addr, SRC_W * SRC_H - 1);
        ref_seq = got;

        // Image 2.
        run_frame(2, 0, -1, -1, 0);
        verify_frame(2, 0);
        check("sel2_first_addr", first_addr, 2 * SRC_W * SRC_H);
        check("sel2_last_addr", last_addr, 3 * SRC_W * SRC_H - 1);

        // Out-of-range selector falls back to image 0.
        run_frame(7, 0, -1, -1, 0);
        verify_frame(7, 0);
        check("sel7_first_addr", first_addr, 0);

        // Random back-pressure with a start pulse and selector change mid-frame.
        run_frame(0, 1, NPIX / 3, -1, 0);
        verify_frame(0, 0);
        diffs = 0;
        for (int i = 0; i < got.size() && i < ref_seq.size(); i++)
            if (got[i] !== ref_seq[i]) diffs++;
        check("stalled_seq_len", got.size(), ref_seq.size());
        check("stalled_seq_diffs", diffs, 0);

        // Reset mid-frame, then a complete frame.
        run_frame(1, 1, -1, 100, 0);
        run_frame(1, 0, -1, -1, 0);
        verify_frame(1, 0);
        check("post_reset_first_addr", first_addr, SRC_W * SRC_H);

`ifdef ILI_SCALER_MIRROR_EN
        run_frame(0, 0, -1, -1, 1);
        verify_frame(0, 1);
        check("mirror_pix0", pix_at(0), SRC_W - 1);
        check("mirror_pix2", pix_at(2), SRC_W - 1);
        check("mirror_row_end", pix_at(SRC_W * SCALE - 3), 0);
        check("mirror_first_addr", first_addr, SRC_W - 1);
`endif

        // Random ROM contents, random selector, random back-pressure.
        for (int i = 0; i < ROM_N; i++) rom[i] = PIXW'($urandom);
        rsel = int'($urandom_range(0, 7));
        run_frame(rsel, 1, NPIX / 2, -1, 0);
        verify_frame(rsel, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
